// File: rtl/system_0_nios2_qsys_0_cpu_mul_combine.sv
// Multiplier combine stage: reduces the three 16x16 partial products from the
// M stage into the low 32 bits of the 32x32 product over two enabled stages
// (A1, A2). The only control state is the pair of stage valid bits.
module system_0_nios2_qsys_0_cpu_mul_combine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        A_en,
  input  logic        A_kill,
  input  logic        M_mul_valid,
  input  logic [4:0]  M_mul_dst,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic [31:0] A_mul_result,
  output logic        A_mul_valid,
  output logic [4:0]  A_mul_dst,
  output logic        A_mul_busy
);

  logic [31:0] a1_p1;
  logic [15:0] a1_cross;
  logic [4:0]  a1_dst;
  logic        a1_valid;
  logic [15:0] cross_sum;
  logic [31:0] final_sum;

  // Only the low halves of the cross products reach bits below 32.
  always_comb begin
    cross_sum = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    final_sum = a1_p1 + {a1_cross, 16'h0000};
  end

  // Data registers load on every enabled edge; kill does not touch data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1_p1        <= 32'h0;
      a1_cross     <= 16'h0;
      a1_dst       <= 5'h0;
      A_mul_result <= 32'h0;
      A_mul_dst    <= 5'h0;
    end else if (A_en) begin
      a1_p1        <= M_mul_cell_p1;
      a1_cross     <= cross_sum;
      a1_dst       <= M_mul_dst;
      A_mul_result <= final_sum;
      A_mul_dst    <= a1_dst;
    end
  end

  // Valid shift: kill clears both stages even while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1_valid    <= 1'b0;
      A_mul_valid <= 1'b0;
    end else if (A_kill) begin
      a1_valid    <= 1'b0;
      A_mul_valid <= 1'b0;
    end else if (A_en) begin
      a1_valid    <= M_mul_valid;
      A_mul_valid <= a1_valid;
    end
  end

  assign A_mul_busy = a1_valid | A_mul_valid;

endmodule
